// File: rtl/vga_tile_scanner_if.sv
// Board input, tile ROM port and video output of the 4x4 tile scanner.
// The master modport is the scanner side; the slave modport is its environment.
interface vga_tile_scanner_if #(
    parameter int DATA_W = 12
);
    logic [16*DATA_W-1:0] board_in;
    logic                 board_load;
    logic [DATA_W-1:0]    memory_select;
    logic [7:0]           row_off;
    logic [7:0]           col_off;
    logic                 pixel_in;
    logic                 hsync;
    logic                 vsync;
    logic                 blank;
    logic [23:0]          rgb;

    modport master (
        input  board_in, board_load, pixel_in,
        output memory_select, row_off, col_off, hsync, vsync, blank, rgb
    );

    modport slave (
        output board_in, board_load, pixel_in,
        input  memory_select, row_off, col_off, hsync, vsync, blank, rgb
    );
endinterface

// File: rtl/vga_tile_scanner.sv
// VGA raster scanner for a 4x4 board of square tiles: a two-stage pixel pipeline
// drives a tile image ROM and maps its 1-bit response to colour.
module vga_tile_scanner #(
    parameter int DATA_W   = 12,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BOARD_X0 = 80,
    parameter int TILE     = 120
) (
    input  logic               clk,
    input  logic               rst,
    vga_tile_scanner_if.master bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0]  BX_BEG   = 10'(BOARD_X0);
    localparam logic [9:0]  BX_END   = 10'(BOARD_X0 + 4 * TILE);
    localparam logic [9:0]  BY_END   = 10'(4 * TILE);
    localparam logic [7:0]  T_LAST   = 8'(TILE - 1);

    localparam logic [23:0] C_BG       = 24'hBBADA0;
    localparam logic [23:0] C_EMPTY_ON = 24'hCDC1B4;
    localparam logic [23:0] C_TILE_ON  = 24'h776E65;
    localparam logic [23:0] C_TILE_OFF = 24'hEEE4DA;

    function automatic logic [23:0] f_colour(input logic inb, input logic nz, input logic px);
        logic [23:0] c;
        if (!inb) begin
            c = C_BG;
        end else if (!nz) begin
            c = px ? C_EMPTY_ON : C_BG;
        end else begin
            c = px ? C_TILE_ON : C_TILE_OFF;
        end
        return c;
    endfunction

    logic                r_pix_en;
    logic [9:0]          r_h_cnt;
    logic [9:0]          r_v_cnt;
    logic [7:0]          r_coff;
    logic [7:0]          r_roff;
    logic [2:0]          r_tcol;
    logic [2:0]          r_trow;
    logic                r_pending;
    logic [DATA_W-1:0]   r_board [16];

    logic [DATA_W-1:0]   r_msel_p1;
    logic [7:0]          r_roff_p1;
    logic [7:0]          r_coff_p1;
    logic                r_inb_p1;
    logic                r_nz_p1;
    logic                r_hs_p1;
    logic                r_vs_p1;
    logic                r_blank_p1;

    logic [23:0]         r_rgb_p2;
    logic                r_hs_p2;
    logic                r_vs_p2;
    logic                r_blank_p2;

    logic                w_h_wrap;
    logic                w_v_wrap;
    logic [9:0]          w_h_next;
    logic [9:0]          w_v_next;
    logic                w_in_board;
    logic                w_visible;
    logic [3:0]          w_cell;
    logic [DATA_W-1:0]   w_tile;
    logic                w_cap_step;
    logic                w_capture;

    assign w_h_wrap   = (r_h_cnt == H_LAST);
    assign w_v_wrap   = (r_v_cnt == V_LAST);
    assign w_h_next   = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    assign w_v_next   = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
    assign w_in_board = (r_h_cnt >= BX_BEG) && (r_h_cnt < BX_END) && (r_v_cnt < BY_END);
    assign w_visible  = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
    assign w_cell     = {r_trow[1:0], r_tcol[1:0]};
    assign w_tile     = r_board[w_cell];
    // The capture point lies in vertical blanking, so a frame never mixes two boards.
    assign w_cap_step = r_pix_en && (r_h_cnt == 10'd0) && (r_v_cnt == V_VIS_C);
    assign w_capture  = w_cap_step && (r_pending || bus.board_load);

    // Raster counters; tile index and offset track the raster so no divider is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= 10'd0;
            r_v_cnt  <= 10'd0;
            r_coff   <= 8'd0;
            r_tcol   <= 3'd0;
            r_roff   <= 8'd0;
            r_trow   <= 3'd0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                r_h_cnt <= w_h_next;
                if (w_h_next <= BX_BEG) begin
                    r_coff <= 8'd0;
                    r_tcol <= 3'd0;
                end else if (r_coff == T_LAST) begin
                    r_coff <= 8'd0;
                    if (r_tcol != 3'd4) begin
                        r_tcol <= r_tcol + 3'd1;
                    end
                end else begin
                    r_coff <= r_coff + 8'd1;
                end

                if (w_h_wrap) begin
                    r_v_cnt <= w_v_next;
                    if (w_v_wrap) begin
                        r_roff <= 8'd0;
                        r_trow <= 3'd0;
                    end else if (r_roff == T_LAST) begin
                        r_roff <= 8'd0;
                        if (r_trow != 3'd4) begin
                            r_trow <= r_trow + 3'd1;
                        end
                    end else begin
                        r_roff <= r_roff + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_board[i] <= '0;
            end
        end else if (w_capture) begin
            r_pending <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_board[i] <= bus.board_in[DATA_W*i +: DATA_W];
            end
        end else if (bus.board_load) begin
            r_pending <= 1'b1;
        end
    end

    // Stage 1: ROM address and delayed timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msel_p1  <= '0;
            r_roff_p1  <= 8'd0;
            r_coff_p1  <= 8'd0;
            r_inb_p1   <= 1'b0;
            r_nz_p1    <= 1'b0;
            r_hs_p1    <= 1'b1;
            r_vs_p1    <= 1'b1;
            r_blank_p1 <= 1'b1;
        end else if (r_pix_en) begin
            r_inb_p1   <= w_in_board;
            r_blank_p1 <= ~w_visible;
            r_hs_p1    <= ~((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
            r_vs_p1    <= ~((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
            if (w_in_board) begin
                r_msel_p1 <= w_tile;
                r_roff_p1 <= r_roff;
                r_coff_p1 <= r_coff;
                r_nz_p1   <= |w_tile;
            end else begin
                r_msel_p1 <= '0;
                r_roff_p1 <= 8'd0;
                r_coff_p1 <= 8'd0;
                r_nz_p1   <= 1'b0;
            end
        end
    end

    // Stage 2: colour from the ROM response to stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb_p2   <= 24'd0;
            r_hs_p2    <= 1'b1;
            r_vs_p2    <= 1'b1;
            r_blank_p2 <= 1'b1;
        end else if (r_pix_en) begin
            r_rgb_p2   <= r_blank_p1 ? 24'd0 : f_colour(r_inb_p1, r_nz_p1, bus.pixel_in);
            r_hs_p2    <= r_hs_p1;
            r_vs_p2    <= r_vs_p1;
            r_blank_p2 <= r_blank_p1;
        end
    end

    assign bus.memory_select = r_msel_p1;
    assign bus.row_off       = r_roff_p1;
    assign bus.col_off       = r_coff_p1;
    assign bus.rgb           = r_rgb_p2;
    assign bus.hsync         = r_hs_p2;
    assign bus.vsync         = r_vs_p2;
    assign bus.blank         = r_blank_p2;

endmodule

// File: tb/tb_vga_tile_scanner.sv
// Bench for vga_tile_scanner on a reduced raster (6x6 tiles, 40x30 total) so whole
// frames fit in a short run; a reference raster model feeds a scoreboard queue.
module tb_vga_tile_scanner;
    localparam int TILE   = 6;
    localparam int BX0    = 4;
    localparam int H_VIS  = 32;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 4;
    localparam int H_BP   = 2;
    localparam int V_VIS  = 24;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 2;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] msel;
        logic [7:0]  roff;
        logic [7:0]  coff;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] msel;
        logic [7:0]  roff;
        logic [7:0]  coff;
        logic [23:0] rgb;
    } probe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    vga_tile_scanner_if #(.DATA_W(12)) bus ();

    int rom_mode = 1;

    function automatic logic rom_px(int mode, logic [11:0] t, logic [7:0] r, logic [7:0] c);
        logic p;
        case (mode)
            0:       p = 1'b1;
            1:       p = r[0] ^ c[0] ^ t[1];
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    assign bus.pixel_in = rom_px(rom_mode, bus.memory_select, bus.row_off, bus.col_off);

    vga_tile_scanner #(
        .DATA_W(12), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BOARD_X0(BX0), .TILE(TILE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q[$];
    probe_t      probes[10];
    bit          probe_en = 0;
    int          mh, mv;
    logic [11:0] mboard[16];
    bit          mpend;
    bit          prev_vs;
    bit          frame_seen;
    int          st_steps, st_hs_low, st_vs_low;
    logic [191:0] b1, b2, b3, b4;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(int h, int v);
        exp_t e;
        bit vis, inb;
        logic px;
        e.h = h;
        e.v = v;
        e.msel = 12'd0;
        e.roff = 8'd0;
        e.coff = 8'd0;
        vis = (h < H_VIS) && (v < V_VIS);
        inb = (h >= BX0) && (h < BX0 + 4 * TILE) && (v < 4 * TILE);
        if (inb) begin
            e.msel = mboard[(v / TILE) * 4 + (h - BX0) / TILE];
            e.roff = 8'(v % TILE);
            e.coff = 8'((h - BX0) % TILE);
        end
        px = rom_px(rom_mode, e.msel, e.roff, e.coff);
        e.hs = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
        e.vs = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
        e.blank = !vis;
        if (!vis)              e.rgb = 24'h000000;
        else if (!inb)         e.rgb = 24'hBBADA0;
        else if (e.msel == 0)  e.rgb = px ? 24'hCDC1B4 : 24'hBBADA0;
        else                   e.rgb = px ? 24'h776E65 : 24'hEEE4DA;
        return e;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        mpend = 0;
        for (int i = 0; i < 16; i++) mboard[i] = 12'd0;
        q.delete();
        prev_vs = 1;
        frame_seen = 0;
        st_steps = 0;
        st_hs_low = 0;
        st_vs_low = 0;
    endtask

    task automatic sync_stats();
        if (!bus.vsync && prev_vs) begin
            if (frame_seen) begin
                chk("vsync_period_steps", 32'(st_steps), 32'(H_TOT * V_TOT));
                chk("hsync_low_steps", 32'(st_hs_low), 32'(H_SYNC * V_TOT));
                chk("vsync_low_steps", 32'(st_vs_low), 32'(V_SYNC * H_TOT));
            end
            frame_seen = 1;
            st_steps = 0;
            st_hs_low = 0;
            st_vs_low = 0;
        end
        st_steps++;
        if (!bus.hsync) st_hs_low++;
        if (!bus.vsync) st_vs_low++;
        prev_vs = bus.vsync;
    endtask

    // One pixel step: board_load (if any) is presented in the pix_en=1 cycle.
    task automatic step(input bit ld);
        exp_t e, c1, c2;
        e = model(mh, mv);
        q.push_back(e);
        if (mh == 0 && mv == V_VIS && (mpend || ld)) begin
            for (int i = 0; i < 16; i++) mboard[i] = bus.board_in[12*i +: 12];
            mpend = 0;
        end else if (ld) begin
            mpend = 1;
        end
        @(posedge clk);
        #1 bus.board_load = ld;
        @(posedge clk);
        #1 bus.board_load = 1'b0;
        mh++;
        if (mh == H_TOT) begin
            mh = 0;
            mv++;
            if (mv == V_TOT) mv = 0;
        end
        c1 = q[$];
        chk("memory_select", 32'(bus.memory_select), 32'(c1.msel));
        chk("row_off", 32'(bus.row_off), 32'(c1.roff));
        chk("col_off", 32'(bus.col_off), 32'(c1.coff));
        if (probe_en) begin
            for (int k = 0; k < 10; k++) begin
                if (probes[k].x == c1.h && probes[k].y == c1.v) begin
                    chk("probe_msel", 32'(bus.memory_select), 32'(probes[k].msel));
                    chk("probe_row_off", 32'(bus.row_off), 32'(probes[k].roff));
                    chk("probe_col_off", 32'(bus.col_off), 32'(probes[k].coff));
                end
            end
        end
        if (q.size() >= 2) begin
            c2 = q.pop_front();
            chk("hsync", 32'(bus.hsync), 32'(c2.hs));
            chk("vsync", 32'(bus.vsync), 32'(c2.vs));
            chk("blank", 32'(bus.blank), 32'(c2.blank));
            chk("rgb", 32'(bus.rgb), 32'(c2.rgb));
            if (probe_en) begin
                for (int k = 0; k < 10; k++) begin
                    if (probes[k].x == c2.h && probes[k].y == c2.v)
                        chk("probe_rgb", 32'(bus.rgb), 32'(probes[k].rgb));
                end
            end
            sync_stats();
        end else begin
            chk("first_step_hsync", 32'(bus.hsync), 32'd1);
            chk("first_step_vsync", 32'(bus.vsync), 32'd1);
            chk("first_step_blank", 32'(bus.blank), 32'd1);
            chk("first_step_rgb", 32'(bus.rgb), 32'd0);
        end
    endtask

    task automatic run_until(input int h, input int v);
        int n;
        n = 0;
        while (!(mh == h && mv == v)) begin
            if (n >= 2 * H_TOT * V_TOT) begin
                n_chk++;
                n_fail++;
                $display("FAIL run_until: position %0d,%0d not reached in %0d steps", h, v, n);
                break;
            end
            step(1'b0);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_memory_select", 32'(bus.memory_select), 32'd0);
        chk("rst_row_off", 32'(bus.row_off), 32'd0);
        chk("rst_col_off", 32'(bus.col_off), 32'd0);
        chk("rst_hsync", 32'(bus.hsync), 32'd1);
        chk("rst_vsync", 32'(bus.vsync), 32'd1);
        chk("rst_blank", 32'(bus.blank), 32'd1);
        chk("rst_rgb", 32'(bus.rgb), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        probes[0] = '{x: 4,  y: 0,  msel: 12'd4,     roff: 8'd0, coff: 8'd0, rgb: 24'h776E65};
        probes[1] = '{x: 9,  y: 5,  msel: 12'd4,     roff: 8'd5, coff: 8'd5, rgb: 24'h776E65};
        probes[2] = '{x: 10, y: 6,  msel: 12'd2,     roff: 8'd0, coff: 8'd0, rgb: 24'h776E65};
        probes[3] = '{x: 15, y: 11, msel: 12'd2,     roff: 8'd5, coff: 8'd5, rgb: 24'h776E65};
        probes[4] = '{x: 16, y: 0,  msel: 12'd0,     roff: 8'd0, coff: 8'd0, rgb: 24'hCDC1B4};
        probes[5] = '{x: 27, y: 23, msel: 12'hABC,   roff: 8'd5, coff: 8'd5, rgb: 24'h776E65};
        probes[6] = '{x: 3,  y: 0,  msel: 12'd0,     roff: 8'd0, coff: 8'd0, rgb: 24'hBBADA0};
        probes[7] = '{x: 28, y: 10, msel: 12'd0,     roff: 8'd0, coff: 8'd0, rgb: 24'hBBADA0};
        probes[8] = '{x: 32, y: 0,  msel: 12'd0,     roff: 8'd0, coff: 8'd0, rgb: 24'h000000};
        probes[9] = '{x: 17, y: 13, msel: 12'd0,     roff: 8'd1, coff: 8'd1, rgb: 24'hCDC1B4};

        b1 = '0; b1[0 +: 12] = 12'd4; b1[60 +: 12] = 12'd2; b1[180 +: 12] = 12'hABC;
        b2 = '0; b2[36 +: 12] = 12'h800; b2[144 +: 12] = 12'h7FF;
        b3 = '0; for (int i = 0; i < 16; i++) b3[12*i +: 12] = 12'd8;
        b4 = '0; b4[72 +: 12] = 12'd16; b4[108 +: 12] = 12'd1;

        bus.board_in = '0;
        bus.board_load = 1'b0;
        rom_mode = 1;
        do_reset();

        // Load mid-frame, repeated while pending: old board until the capture point.
        run_until(0, 5);
        bus.board_in = b1;
        step(1'b1);
        run_until(0, 8);
        step(1'b1);
        run_until(0, 25);

        // Full frame of the new board with an all-ones ROM, plus fixed probe points.
        rom_mode = 0;
        probe_en = 1;
        step(1'b0);
        run_until(0, 25);
        probe_en = 0;

        // Load coinciding with the capture step; pending must not survive it.
        rom_mode = 1;
        bus.board_in = b2;
        run_until(0, V_VIS);
        step(1'b1);
        bus.board_in = b3;
        step(1'b0);
        run_until(0, V_VIS);
        step(1'b0);

        // Later load applied at the following capture step.
        run_until(0, 15);
        bus.board_in = b4;
        step(1'b1);
        run_until(0, V_VIS);
        step(1'b0);
        run_until(0, 20);

        // Reset mid-frame with a load pending: the load is discarded.
        run_until(0, 10);
        bus.board_in = b1;
        step(1'b1);
        run_until(0, 12);
        do_reset();
        repeat (2 * H_TOT * V_TOT + 40) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
